// File: rtl/soqpsk_addr_gen.sv
// SOQPSK-TG precoder and waveform-ROM address generator.
// Emits {ternary history index, sample index} per sample strobe.
module soqpsk_addr_gen #(
    parameter int SAMP_LOG2   = 4,
    parameter int ROM_LATENCY = 2
) (
    input  logic       clock,
    input  logic       aclr,
    input  logic       enable,
    input  logic       samp_en,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [8:0] address,
    output logic       addr_valid,
    output logic       sym_tick,
    output logic       rom_valid,
    output logic       underrun
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SAMP_LOG2-1:0] CNT_LAST = '1;

    state_t state, state_nxt;

    logic [SAMP_LOG2-1:0]   cnt, cnt_nxt;
    logic                   k, k_nxt;
    logic                   a1, a1_nxt;
    logic                   a2, a2_nxt;
    logic signed [1:0]      t0, t1, t2;
    logic signed [1:0]      t0_nxt, t1_nxt, t2_nxt;
    logic                   unf_nxt;
    logic                   step;
    logic                   ak;
    logic signed [1:0]      alpha;
    logic [4:0]             idx_nxt;
    logic [ROM_LATENCY-1:0] dly;

    // Ternary digit {-1,0,+1} mapped to base-3 digit {0,1,2}
    function automatic logic [4:0] trit(input logic signed [1:0] t);
        logic [4:0] d;
        unique case (t)
            -2'sd1:  d = 5'd0;
            2'sd0:   d = 5'd1;
            2'sd1:   d = 5'd2;
            default: d = 5'd1;
        endcase
        return d;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        k_nxt     = k;
        a1_nxt    = a1;
        a2_nxt    = a2;
        t0_nxt    = t0;
        t1_nxt    = t1;
        t2_nxt    = t2;
        unf_nxt   = underrun;
        step      = 1'b0;
        bit_ready = 1'b0;
        ak        = a2;
        alpha     = 2'sd0;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
                cnt_nxt = CNT_LAST;
                k_nxt   = 1'b0;
                a1_nxt  = 1'b1;
                a2_nxt  = 1'b1;
                t0_nxt  = 2'sd0;
                t1_nxt  = 2'sd0;
                t2_nxt  = 2'sd0;
                unf_nxt = 1'b0;
            end
            RUN: begin
                if (!enable) state_nxt = IDLE;
                if (samp_en) begin
                    step    = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        bit_ready = bit_valid;
                        // Missing bit repeats a[k-2], forcing alpha=0
                        ak = bit_valid ? bit_in : a2;
                        if (!bit_valid) unf_nxt = 1'b1;
                        // Sign of s*a[k-1]*a_k; s is negative on even k
                        if (ak != a2)
                            alpha = (k ^ a1 ^ ak) ? 2'sd1 : -2'sd1;
                        t2_nxt = t1;
                        t1_nxt = t0;
                        t0_nxt = alpha;
                        a2_nxt = a1;
                        a1_nxt = ak;
                        k_nxt  = ~k;
                    end
                end
            end
        endcase
    end

    assign idx_nxt = 5'd9 * trit(t2_nxt)
                   + 5'd3 * trit(t1_nxt)
                   + trit(t0_nxt);

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state      <= IDLE;
            cnt        <= CNT_LAST;
            k          <= 1'b0;
            a1         <= 1'b1;
            a2         <= 1'b1;
            t0         <= 2'sd0;
            t1         <= 2'sd0;
            t2         <= 2'sd0;
            underrun   <= 1'b0;
            address    <= 9'd0;
            addr_valid <= 1'b0;
            sym_tick   <= 1'b0;
            dly        <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            k          <= k_nxt;
            a1         <= a1_nxt;
            a2         <= a2_nxt;
            t0         <= t0_nxt;
            t1         <= t1_nxt;
            t2         <= t2_nxt;
            underrun   <= unf_nxt;
            addr_valid <= step;
            sym_tick   <= step && (cnt_nxt == '0);
            if (step) address <= {idx_nxt, cnt_nxt};
            // Keeps shifting in IDLE so in-flight ROM reads still qualify
            dly <= ROM_LATENCY'({dly, addr_valid});
        end
    end

    assign rom_valid = dly[ROM_LATENCY-1];

endmodule
